muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative multiply/divide unit with its own controller, owning the HI/LO register pair for the single-cycle core. It accepts a command from the instruction decoder, runs a 32-step shift-add or restoring-divide sequence, then writes HI/LO. It raises a stall request toward the PC/pipeline while a new command or a HI/LO read would collide with an operation in flight.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; the iteration count equals WIDTH.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  command valid from decoder
op  input  3  000 none, 001 mult, 010 multu, 011 madd, 100 maddu, 101 div, 110 divu, 111 reserved
in1  input  WIDTH  rs operand: multiplicand or dividend
in2  input  WIDTH  rt operand: multiplier or divisor
rd_req  input  1  decoder is reading HI/LO this cycle (mfhi/mflo)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse after HI/LO have been written
stall  output  1  core must hold PC and instruction this cycle

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: state IDLE; hi, lo, busy, done = 0; counter = 0. A reset during ITER or FIX aborts the operation: HI/LO become 0 and no done pulse is produced.
- States: IDLE, ITER, FIX.
- IDLE:
  - Accepts a command when start=1 and op is 001–110. On that edge it latches operand magnitudes (signed ops use |x|), latches the sign flags and op, clears the partial product or remainder, sets counter=0, and moves to ITER.
  - op=000 or op=111 is ignored; no state change.
- ITER:
  - Multiply: one shift-add step per cycle.
  - Divide: one restoring subtract/shift step per cycle.
  - counter increments each cycle; after the step with counter=WIDTH-1, the next state is FIX.
- FIX, single cycle:
  - Applies the sign correction and accumulation, writes hi/lo on the exit edge, and moves to IDLE.
  - done=1 in the following cycle.
- Latency: the acceptance edge counts as edge 1; hi/lo are updated on edge WIDTH+2 (34). busy=1 in ITER and FIX, which is 33 cycles.
- Arithmetic rules:
  - mult: 64-bit product of the magnitudes, negated (two's complement) if the operand signs differ.
  - multu: unsigned product.
  - madd / maddu: {hi,lo} <= {hi,lo} + signed or unsigned product, modulo 2^64. The old HI/LO value is sampled in FIX.
  - div / divu: lo = quotient, hi = remainder.
  - Signed divide: the quotient is negated if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - Divisor = 0, both div and divu: lo = all ones, hi = in1 as latched.
  - div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (no trap).
- Stall:
  - stall = busy & (start | rd_req), combinational.
  - While stalled, the core holds start, op, in1 and in2 stable. The unit is non-preemptible.
  - The command is accepted on the first edge with state IDLE, which includes the done cycle.
- The done cycle: hi/lo are already valid, so rd_req causes no stall and a new start is accepted. A read and a start in the same IDLE cycle return the old HI/LO value.
- Operands are not re-sampled after acceptance. Changes on in1/in2 during busy have no effect.

Test Plan:
1. multu 0xFFFFFFFF × 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles; single done pulse on cycle 35.
2. mult 0xFFFFFFFD (-3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then mult 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
3. div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7 / 0 -> lo=0xFFFFFFFF, hi=7. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
4. Accumulation sequence:
   - mult 2×3 -> {0, 6}.
   - madd 0xFFFFFFFF × 1 -> {0, 5}.
   - maddu 0x80000000 × 2 -> hi=1, lo=5.
5. Back-to-back commands:
   - Second start is asserted 5 cycles into the first op -> stall=1 for 29 cycles (until the done cycle).
   - The second command is accepted in the done cycle; both results are correct.
   - rd_req during busy -> stall=1; rd_req with busy=0 -> stall=0.
6. Reset and ignored ops:
   - rst asserted in ITER with counter=10 -> next cycle busy=0, hi=lo=0, no done pulse.
   - A following multu 5×6 -> lo=30.
   - start with op=111 -> busy stays 0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning HI/LO: 32-step shift-add multiply or restoring divide,
// then a single sign-fix/accumulate cycle. States: IDLE (wait cmd) | ITER (one step/cycle) | FIX (write HI/LO).
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_in1,
  input  logic [WIDTH-1:0] i_in2,
  input  logic             i_rd_req,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b011;
  localparam logic [2:0] OP_MADDU = 3'b100;
  localparam logic [2:0] OP_DIV   = 3'b101;
  localparam logic [2:0] OP_DIVU  = 3'b110;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic             r_neg_a, r_neg_b;
  logic [WIDTH-1:0] r_b, r_q, r_rem;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic             r_busy, r_done;

  logic               w_valid_op, w_signed_in, w_neg1, w_neg2, w_is_div, w_is_acc, w_ge;
  logic [WIDTH-1:0]   w_mag1, w_mag2, w_sub, w_quot, w_remd;
  logic [WIDTH:0]     w_sum, w_shift;
  logic [2*WIDTH-1:0] w_prod, w_prod_s, w_acc, w_result;

  assign w_valid_op  = (i_op != 3'b000) && (i_op != 3'b111);
  assign w_signed_in = (i_op == OP_MULT) || (i_op == OP_MADD) || (i_op == OP_DIV);
  assign w_neg1      = w_signed_in & i_in1[WIDTH-1];
  assign w_neg2      = w_signed_in & i_in2[WIDTH-1];
  assign w_mag1      = w_neg1 ? -i_in1 : i_in1;
  assign w_mag2      = w_neg2 ? -i_in2 : i_in2;

  assign w_is_div = (r_op == OP_DIV) || (r_op == OP_DIVU);
  assign w_is_acc = (r_op == OP_MADD) || (r_op == OP_MADDU);

  // Multiply keeps {r_rem, r_q} as the shifting product; divide keeps remainder/quotient there.
  assign w_sum   = {1'b0, r_rem} + ({1'b0, r_b} & {(WIDTH+1){r_q[0]}});
  assign w_shift = {r_rem, r_q[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, r_b};
  assign w_sub   = w_shift[WIDTH-1:0] - r_b;

  // With a zero divisor the remainder ends up holding the dividend magnitude, so re-signing it
  // restores the latched in1 without a separate path.
  assign w_prod   = {r_rem, r_q};
  assign w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
  assign w_acc    = {r_hi, r_lo} + w_prod_s;
  assign w_quot   = (r_b == '0) ? '1 : ((r_neg_a ^ r_neg_b) ? -r_q : r_q);
  assign w_remd   = r_neg_a ? -r_rem : r_rem;
  assign w_result = w_is_div ? {w_remd, w_quot} : (w_is_acc ? w_acc : w_prod_s);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_b     <= '0;
      r_q     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start && w_valid_op) begin
            r_op    <= i_op;
            r_neg_a <= w_neg1;
            r_neg_b <= w_neg2;
            r_q     <= w_mag1;
            r_b     <= w_mag2;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          if (w_is_div) begin
            r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
          end else begin
            r_rem <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          {r_hi, r_lo} <= w_result;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_stall = r_busy & (i_start | i_rd_req);
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model plus directed and random stimulus.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  in1 = '0, in2 = '0;
  logic          rd_req = 1'b0;
  logic [W-1:0]  hi, lo;
  logic          busy, done, stall;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_in1(in1), .i_in2(in2),
    .i_rd_req(rd_req), .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_done(done), .o_stall(stall)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
  endtask

  // Reference arithmetic: plain 64-bit integer math on the operands.
  function automatic logic [63:0] ref_compute(input logic [2:0] o, input logic [31:0] a, b,
                                              input logic [31:0] h, l);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd1: return 64'(sa * sb);
      3'd2: return ua * ub;
      3'd3: return {h, l} + 64'(sa * sb);
      3'd4: return {h, l} + ua * ub;
      3'd5: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd6: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return {h, l};
    endcase
  endfunction

  // Cycle-level model: an accepted command keeps the unit busy for WIDTH+1 edges.
  bit          m_valid = 0, m_busy = 0, m_done = 0, m_acc = 0;
  int          m_cyc = 0;
  logic [2:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_hi = '0, m_lo = '0;

  always @(posedge clk) begin
    m_acc = 0;
    if (rst) begin
      m_valid = 1; m_busy = 0; m_done = 0; m_cyc = 0; m_hi = '0; m_lo = '0;
    end else if (m_busy) begin
      m_cyc++;
      if (m_cyc == W + 1) begin
        {m_hi, m_lo} = ref_compute(m_op, m_a, m_b, m_hi, m_lo);
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      m_done = 0;
      if (start && op != 3'd0 && op != 3'd7) begin
        m_op = op; m_a = in1; m_b = in2; m_busy = 1; m_cyc = 0; m_acc = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("stall", 64'(stall), 64'(m_busy & (start | rd_req)));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, b, input bit chk_res,
                       input logic [31:0] eh, el, input string nm);
    int nb, done_edge;
    bit got;
    @(posedge clk); #1;
    start = 1; op = o; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 0; op = $urandom_range(0, 7); in1 = $urandom; in2 = $urandom;
    nb = busy ? 1 : 0;
    got = 0;
    done_edge = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (done) begin got = 1; done_edge = k + 2; end
      else if (busy) nb++;
    end
    chk({nm, " done seen"}, 64'(got), 64'(1));
    chk({nm, " busy cycles"}, 64'(nb), 64'(33));
    chk({nm, " done cycle"}, 64'(done_edge + 1), 64'(35));
    if (chk_res) begin
      chk({nm, " hi"}, 64'(hi), 64'(eh));
      chk({nm, " lo"}, 64'(lo), 64'(el));
    end
    @(posedge clk); #1;
    chk({nm, " done single"}, 64'(done), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int ns, nd;
    bit got;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    rst = 0;

    chk("model mult", ref_compute(3'd1, 32'hFFFF_FFFD, 32'd7, 0, 0), 64'hFFFF_FFFF_FFFF_FFEB);
    chk("model div", ref_compute(3'd5, 32'hFFFF_FFF9, 32'd2, 0, 0), 64'hFFFF_FFFF_FFFF_FFFD);
    chk("model divovf", ref_compute(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0), 64'h0000_0000_8000_0000);

    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
    do_op(3'd1, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult neg");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, 32'h0, "mult minmin");
    do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div neg");
    do_op(3'd6, 32'd7, 32'd0, 1, 32'd7, 32'hFFFF_FFFF, "divu by0");
    do_op(3'd5, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div by0");
    do_op(3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, "div ovf");
    do_op(3'd1, 32'd2, 32'd3, 1, 32'h0, 32'd6, "acc mult");
    do_op(3'd3, 32'hFFFF_FFFF, 32'd1, 1, 32'h0, 32'd5, "acc madd");
    do_op(3'd4, 32'h8000_0000, 32'd2, 1, 32'h1, 32'd5, "acc maddu");

    // Back-to-back: second start raised 5 cycles into the first op.
    @(posedge clk); #1;
    start = 1; op = 3'd2; in1 = 32'h1234_5678; in2 = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #1;
    start = 1; op = 3'd1; in1 = 32'hFFFF_FFFD; in2 = 32'd7;
    #1;
    ns = 0;
    for (int k = 0; k < 40; k++) begin
      if (!stall) break;
      ns++;
      @(posedge clk); #2;
    end
    chk("b2b stall cycles", 64'(ns), 64'(29));
    chk("b2b done cycle", 64'(done), 64'(1));
    @(posedge clk); #1;
    start = 0;
    chk("b2b accepted", 64'(busy), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    rd_req = 1;
    #1;
    chk("rd stall busy", 64'(stall), 64'(1));
    @(posedge clk); #1;
    rd_req = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      if (done) got = 1;
    end
    chk("b2b second done", 64'(got), 64'(1));
    chk("b2b hi", 64'(hi), 64'(32'hFFFF_FFFF));
    chk("b2b lo", 64'(lo), 64'(32'hFFFF_FFEB));
    rd_req = 1;
    #1;
    chk("rd stall idle", 64'(stall), 64'(0));
    @(posedge clk); #1;
    rd_req = 0;

    // Reset in ITER with counter=10 aborts the op.
    @(posedge clk); #1;
    start = 1; op = 3'd2; in1 = 32'hFFFF_FFFF; in2 = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    start = 0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort hi", 64'(hi), 64'(0));
    chk("abort lo", 64'(lo), 64'(0));
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort no done", 64'(nd), 64'(0));
    do_op(3'd2, 32'd5, 32'd6, 1, 32'h0, 32'd30, "multu 5x6");
    @(posedge clk); #1;
    start = 1; op = 3'd7; in1 = 32'd3; in2 = 32'd4;
    @(posedge clk); #1;
    chk("op111 ignored", 64'(busy), 64'(0));
    start = 0; op = 3'd0;
    @(posedge clk); #1;
    chk("op000 ignored", 64'(busy), 64'(0));

    // Random traffic; a valid start is held until the model reports it accepted.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 399) == 0);
      rd_req = ($urandom_range(0, 3) == 0);
      if (!(start && op != 3'd0 && op != 3'd7 && !m_acc)) begin
        start = ($urandom_range(0, 5) == 0);
        op = $urandom_range(0, 7);
        in1 = pick();
        in2 = pick();
      end
    end
    @(posedge clk); #1;
    rst = 0; start = 0; rd_req = 0; op = 3'd0;
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
